uart8_transceiver: RTL and testbench

- Full-duplex 8N1 UART: one transmitter, one receiver, and an internal baud generator, all in a single clock domain.
- Sits between a byte-wide parallel interface and a serial pin pair.
- Frame format: one start bit (0), eight data bits LSB first, one stop bit (1).
- Optional "turbo" mode sends back-to-back frames with no idle gap.

---
 rtl/uart8_transceiver.sv | 237 +++++++++++++++++++++++
 tb/tb_uart8_transceiver.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart8_transceiver.sv
// 8N1 UART transceiver: free-running baud generator, a transmitter and a
// 16x oversampling receiver sharing one clock. TX and RX run independently.
module uart8_transceiver #(
  parameter int CLOCK_RATE   = 12000000,
  parameter int BAUD_RATE    = 9600,
  parameter int TURBO_FRAMES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxEn,
  input  logic       rxIn,
  output logic       rxBusy,
  output logic       rxDone,
  output logic       rxErr,
  output logic [7:0] rxOut,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] txIn,
  output logic       txBusy,
  output logic       txDone,
  output logic       txOut
);

  localparam int TX_DIV = CLOCK_RATE / BAUD_RATE;
  localparam int RX_DIV = CLOCK_RATE / (16 * BAUD_RATE);
  localparam int TXW    = $clog2(TX_DIV + 1);
  localparam int RXW    = $clog2(RX_DIV + 1);
  localparam logic [TXW-1:0] TX_LAST = TXW'(TX_DIV - 1);
  localparam logic [TXW-1:0] TX_HALF = TXW'(TX_DIV / 2 - 1);
  localparam logic [RXW-1:0] RX_LAST = RXW'(RX_DIV - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_READY} rx_state_t;

  logic [TXW-1:0] tx_cnt;
  logic [RXW-1:0] rx_cnt;
  logic           tx_tick, rx_tick;
  logic           txClk;

  tx_state_t      tx_state;
  logic [7:0]     tx_shift;
  logic [2:0]     tx_bit;

  rx_state_t      rx_state;
  logic [1:0]     rx_sync;
  logic           rx_prev;
  logic           rx_s, rx_fall;
  logic [7:0]     rx_shift;
  logic [2:0]     rx_bit;
  logic [3:0]     rx_smp;

  assign tx_tick = (tx_cnt == TX_LAST);
  assign rx_tick = (rx_cnt == RX_LAST);
  assign rx_s    = rx_sync[1];
  assign rx_fall = rx_prev & ~rx_s;

  // Baud counters; txClk rises on the same edge the TX FSM advances.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_cnt <= '0;
      rx_cnt <= '0;
      txClk  <= 1'b0;
    end else begin
      if (tx_tick) begin
        tx_cnt <= '0;
        txClk  <= 1'b1;
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
        if (tx_cnt == TX_HALF) txClk <= 1'b0;
      end
      rx_cnt <= rx_tick ? '0 : rx_cnt + 1'b1;
    end
  end

  // Transmitter. In turbo mode the DONE period doubles as the stop bit so the
  // next start bit follows it directly; otherwise DONE is one idle bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_shift <= '0;
      tx_bit   <= '0;
      txOut    <= 1'b1;
      txBusy   <= 1'b0;
      txDone   <= 1'b0;
    end else if (!txEn) begin
      tx_state <= TX_IDLE;
      txOut    <= 1'b1;
      txBusy   <= 1'b0;
      txDone   <= 1'b0;
    end else if (tx_tick) begin
      unique case (tx_state)
        TX_IDLE: begin
          txOut  <= 1'b1;
          txBusy <= 1'b0;
          txDone <= 1'b0;
          if (txStart) begin
            tx_shift <= txIn;
            tx_state <= TX_START;
            txOut    <= 1'b0;
            txBusy   <= 1'b1;
          end
        end
        TX_START: begin
          txOut    <= tx_shift[0];
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_bit   <= '0;
          tx_state <= TX_DATA;
        end
        TX_DATA: begin
          if (tx_bit == 3'd7) begin
            txOut <= 1'b1;
            if (TURBO_FRAMES != 0) begin
              tx_state <= TX_DONE;
              txBusy   <= 1'b0;
              txDone   <= 1'b1;
            end else begin
              tx_state <= TX_STOP;
            end
          end else begin
            txOut    <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= tx_bit + 1'b1;
          end
        end
        TX_STOP: begin
          tx_state <= TX_DONE;
          txBusy   <= 1'b0;
          txDone   <= 1'b1;
        end
        TX_DONE: begin
          txDone <= 1'b0;
          if (txStart) begin
            tx_shift <= txIn;
            tx_state <= TX_START;
            txOut    <= 1'b0;
            txBusy   <= 1'b1;
          end else begin
            tx_state <= TX_IDLE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rxIn};
      rx_prev <= rx_s;
    end
  end

  // Receiver. A start edge is also accepted in READY so back-to-back frames
  // from a turbo sender are not missed; that cuts rxDone short.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_shift <= '0;
      rx_bit   <= '0;
      rx_smp   <= '0;
      rxBusy   <= 1'b0;
      rxDone   <= 1'b0;
      rxErr    <= 1'b0;
      rxOut    <= 8'h00;
    end else if (!rxEn) begin
      rx_state <= RX_IDLE;
      rxBusy   <= 1'b0;
      rxDone   <= 1'b0;
      rxErr    <= 1'b0;
    end else if ((rx_state == RX_IDLE || rx_state == RX_READY) && rx_fall) begin
      rx_state <= RX_START;
      rx_smp   <= '0;
      rxBusy   <= 1'b1;
      rxDone   <= 1'b0;
      rxErr    <= 1'b0;
    end else if (rx_tick) begin
      unique case (rx_state)
        RX_IDLE: ;
        RX_START: begin
          if (rx_smp == 4'd7) begin
            rx_smp <= '0;
            rx_bit <= '0;
            if (rx_s) begin
              rx_state <= RX_IDLE;
              rxBusy   <= 1'b0;
            end else begin
              rx_state <= RX_DATA;
            end
          end else begin
            rx_smp <= rx_smp + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_smp == 4'd15) begin
            rx_smp   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else rx_bit <= rx_bit + 1'b1;
          end else begin
            rx_smp <= rx_smp + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_smp == 4'd15) begin
            rx_smp <= '0;
            rxBusy <= 1'b0;
            if (rx_s) begin
              rxOut    <= rx_shift;
              rxDone   <= 1'b1;
              rx_state <= RX_READY;
            end else begin
              rxErr    <= 1'b1;
              rx_state <= RX_IDLE;
            end
          end else begin
            rx_smp <= rx_smp + 1'b1;
          end
        end
        RX_READY: begin
          if (rx_smp == 4'd15) begin
            rx_smp   <= '0;
            rxDone   <= 1'b0;
            rx_state <= RX_IDLE;
          end else begin
            rx_smp <= rx_smp + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart8_transceiver.sv
// Directed bench: default-rate DUT (non-turbo) in loopback plus a fast
// turbo-mode DUT, covering framing, latency, errors, glitches and aborts.
module tb_uart8_transceiver;

  logic       clk = 1'b0;
  logic       reset, rxEn, txEn, txStart, lb, rx_drv;
  logic [7:0] txIn;
  logic       rxIn, rxBusy, rxDone, rxErr, txBusy, txDone, txOut;
  logic [7:0] rxOut;

  logic       t_txEn, t_txStart;
  logic [7:0] t_txIn, t_rxOut;
  logic       t_rxBusy, t_rxDone, t_rxErr, t_txBusy, t_txDone, t_txOut;

  int compared = 0;
  int mismatched = 0;

  assign rxIn = lb ? txOut : rx_drv;

  always #5 clk = ~clk;

  uart8_transceiver dut (
    .clk(clk), .reset(reset), .rxEn(rxEn), .rxIn(rxIn), .rxBusy(rxBusy),
    .rxDone(rxDone), .rxErr(rxErr), .rxOut(rxOut), .txEn(txEn),
    .txStart(txStart), .txIn(txIn), .txBusy(txBusy), .txDone(txDone),
    .txOut(txOut)
  );

  // 16 clocks per bit, one rxTick per clock.
  uart8_transceiver #(.CLOCK_RATE(153600), .BAUD_RATE(9600), .TURBO_FRAMES(1)) dut_t (
    .clk(clk), .reset(reset), .rxEn(rxEn), .rxIn(t_txOut), .rxBusy(t_rxBusy),
    .rxDone(t_rxDone), .rxErr(t_rxErr), .rxOut(t_rxOut), .txEn(t_txEn),
    .txStart(t_txStart), .txIn(t_txIn), .txBusy(t_txBusy), .txDone(t_txDone),
    .txOut(t_txOut)
  );

  task automatic test_reset();
    logic [13:0] got;
    reset = 1'b0; rxEn = 1'b1; txEn = 1'b0; txStart = 1'b0; txIn = 8'h00;
    lb = 1'b1; rx_drv = 1'b1;
    t_txEn = 1'b0; t_txStart = 1'b0; t_txIn = 8'h00;
    repeat (3) @(negedge clk);
    got = {txOut, txBusy, txDone, rxBusy, rxDone, rxErr, rxOut};
    compared++;
    if (got !== {1'b1, 5'b0, 8'h00}) begin
      mismatched++;
      $display("FAIL reset_state: got %h want %h", got, {1'b1, 5'b0, 8'h00});
    end
    compared++;
    if (dut.txClk !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_txclk: got %b want 0", dut.txClk);
    end
  endtask

  task automatic test_loopback();
    int st[4];
    int rt[4];
    logic [9:0] fr[4];
    logic [7:0] rv[4];
    logic re[4];
    int nf = 0, nd = 0, lat;
    logic pb = 1'b0, pd = 1'b0, pc = 1'b0, done_mid = 1'b0, dropped = 1'b0;
    for (int k = 0; k < 4; k++) begin st[k] = 0; rt[k] = 0; fr[k] = '0; rv[k] = '0; re[k] = 1'b0; end
    txEn = 1'b1; txStart = 1'b1; txIn = 8'h7A;
    @(negedge clk); reset = 1'b1;
    for (int cyc = 0; cyc < 32000; cyc++) begin
      @(negedge clk);
      if (txBusy && !pb) begin
        if (nf < 4) st[nf] = cyc;
        nf++;
      end
      if (nf > 0 && nf <= 4) begin
        int rel = cyc - st[nf-1];
        if (rel % 1250 == 625 && rel / 1250 < 10) fr[nf-1][rel / 1250] = txOut;
        if (nf == 1 && rel == 3 * 1250) txIn = 8'hB1;
        if (nf == 1 && rel == 10 * 1250 + 625) done_mid = txDone;
      end
      if (rxDone && !pd) begin
        if (nd < 4) begin rv[nd] = rxOut; re[nd] = rxErr; rt[nd] = cyc; end
        nd++;
      end
      if (dut.txClk && !pc && rxDone && nd == 2 && !dropped) begin
        txStart = 1'b0;
        dropped = 1'b1;
      end
      pb = txBusy; pd = rxDone; pc = dut.txClk;
    end
    compared++;
    if (nf !== 2) begin mismatched++; $display("FAIL lb_frame_count: got %0d want 2", nf); end
    compared++;
    if (fr[0] !== {1'b1, 8'h7A, 1'b0}) begin
      mismatched++; $display("FAIL lb_frame1_bits: got %b want %b", fr[0], {1'b1, 8'h7A, 1'b0});
    end
    compared++;
    if (fr[1] !== {1'b1, 8'hB1, 1'b0}) begin
      mismatched++; $display("FAIL lb_frame2_bits: got %b want %b", fr[1], {1'b1, 8'hB1, 1'b0});
    end
    compared++;
    if (st[1] - st[0] !== 13750) begin
      mismatched++; $display("FAIL lb_start_spacing: got %0d want 13750", st[1] - st[0]);
    end
    compared++;
    if (done_mid !== 1'b1) begin mismatched++; $display("FAIL lb_txdone: got %b want 1", done_mid); end
    compared++;
    if (nd !== 2) begin mismatched++; $display("FAIL lb_rxdone_count: got %0d want 2", nd); end
    compared++;
    if ({rv[0], rv[1]} !== 16'h7AB1) begin
      mismatched++; $display("FAIL lb_rx_bytes: got %h want 7ab1", {rv[0], rv[1]});
    end
    compared++;
    if ({re[0], re[1]} !== 2'b00) begin
      mismatched++; $display("FAIL lb_rx_err: got %b want 00", {re[0], re[1]});
    end
    lat = rt[0] - st[0];
    compared++;
    if ((lat > 11000 && lat <= 12500) !== 1'b1) begin
      mismatched++; $display("FAIL lb_rx_latency: got %0d want 11001..12500", lat);
    end
    compared++;
    if ({txOut, txBusy} !== 2'b10) begin
      mismatched++; $display("FAIL lb_tx_stopped: got %b want 10", {txOut, txBusy});
    end
  endtask

  task automatic test_framing_error();
    logic [9:0] fb = {1'b0, 8'h55, 1'b0};
    logic saw_done = 1'b0;
    lb = 1'b0; rx_drv = 1'b1;
    repeat (100) @(negedge clk);
    for (int j = 0; j < 11; j++) begin
      rx_drv = (j < 10) ? fb[j] : 1'b1;
      repeat (1250) begin
        @(negedge clk);
        if (rxDone) saw_done = 1'b1;
      end
    end
    compared++;
    if (saw_done !== 1'b0) begin mismatched++; $display("FAIL ferr_no_done: got %b want 0", saw_done); end
    compared++;
    if ({rxErr, rxBusy} !== 2'b10) begin
      mismatched++; $display("FAIL ferr_flags: got err,busy=%b want 10", {rxErr, rxBusy});
    end
    compared++;
    if (rxOut !== 8'hB1) begin mismatched++; $display("FAIL ferr_rxout_held: got %h want b1", rxOut); end
  endtask

  task automatic test_glitch();
    logic late_busy = 1'b0, any_done = 1'b0;
    rx_drv = 1'b0;
    repeat (312) @(negedge clk);
    rx_drv = 1'b1;
    for (int cyc = 312; cyc < 2500; cyc++) begin
      @(negedge clk);
      if (cyc >= 700 && rxBusy) late_busy = 1'b1;
      if (rxDone) any_done = 1'b1;
    end
    compared++;
    if ({late_busy, any_done, rxErr} !== 3'b000) begin
      mismatched++; $display("FAIL glitch: got busy,done,err=%b want 000", {late_busy, any_done, rxErr});
    end
  endtask

  task automatic test_turbo();
    int st[4];
    logic [9:0] fr[4];
    logic [7:0] rv[4];
    int nf = 0, nd = 0;
    logic pb = 1'b0, pd = 1'b0, done_mid = 1'b0;
    for (int k = 0; k < 4; k++) begin st[k] = 0; fr[k] = '0; rv[k] = '0; end
    t_txEn = 1'b1; t_txStart = 1'b1; t_txIn = 8'h3C;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      if (t_txBusy && !pb) begin
        if (nf < 4) st[nf] = cyc;
        nf++;
        if (nf == 2) t_txStart = 1'b0;
      end
      if (nf > 0 && nf <= 4) begin
        int rel = cyc - st[nf-1];
        if (rel % 16 == 8 && rel / 16 < 10) fr[nf-1][rel / 16] = t_txOut;
        if (nf == 1 && rel == 40) t_txIn = 8'hC5;
        if (nf == 1 && rel == 152) done_mid = t_txDone;
      end
      if (t_rxDone && !pd) begin
        if (nd < 4) rv[nd] = t_rxOut;
        nd++;
      end
      pb = t_txBusy; pd = t_rxDone;
    end
    compared++;
    if (nf !== 2) begin mismatched++; $display("FAIL turbo_frame_count: got %0d want 2", nf); end
    compared++;
    if (st[1] - st[0] !== 160) begin
      mismatched++; $display("FAIL turbo_no_gap: got %0d want 160", st[1] - st[0]);
    end
    compared++;
    if ({fr[0], fr[1]} !== {1'b1, 8'h3C, 1'b0, 1'b1, 8'hC5, 1'b0}) begin
      mismatched++; $display("FAIL turbo_bits: got %b %b want %b %b", fr[0], fr[1],
                             {1'b1, 8'h3C, 1'b0}, {1'b1, 8'hC5, 1'b0});
    end
    compared++;
    if (done_mid !== 1'b1) begin mismatched++; $display("FAIL turbo_txdone: got %b want 1", done_mid); end
    compared++;
    if (nd !== 2 || {rv[0], rv[1]} !== 16'h3CC5) begin
      mismatched++; $display("FAIL turbo_rx: got n=%0d %h want n=2 3cc5", nd, {rv[0], rv[1]});
    end
    compared++;
    if (t_txOut !== 1'b1) begin mismatched++; $display("FAIL turbo_idle_line: got %b want 1", t_txOut); end
  endtask

  task automatic wait_busy(input string name);
    logic seen = 1'b0;
    for (int cyc = 0; cyc < 2600 && !seen; cyc++) begin
      @(negedge clk);
      if (txBusy) seen = 1'b1;
    end
    compared++;
    if (seen !== 1'b1) begin mismatched++; $display("FAIL %s: got busy=0 want 1 within 2600 clks", name); end
  endtask

  task automatic test_abort();
    lb = 1'b1; txIn = 8'hA5; txStart = 1'b1; txEn = 1'b1;
    wait_busy("abort_start1");
    repeat (3000) @(negedge clk);
    compared++;
    if (rxBusy !== 1'b1) begin mismatched++; $display("FAIL abort_rx_active: got %b want 1", rxBusy); end
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if ({txOut, txBusy, txDone, rxBusy, rxDone, rxErr, rxOut} !== {1'b1, 5'b0, 8'h00}) begin
      mismatched++; $display("FAIL abort_reset: got %h want %h",
                             {txOut, txBusy, txDone, rxBusy, rxDone, rxErr, rxOut}, {1'b1, 5'b0, 8'h00});
    end
    reset = 1'b1;
    wait_busy("abort_start2");
    repeat (3000) @(negedge clk);
    txEn = 1'b0;
    @(negedge clk);
    compared++;
    if ({txOut, txBusy, txDone} !== 3'b100) begin
      mismatched++; $display("FAIL abort_txen: got %b want 100", {txOut, txBusy, txDone});
    end
    txStart = 1'b0;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_framing_error();
    test_glitch();
    test_turbo();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
